bcd_sub_seq: RTL and testbench



---
 rtl/bcd_pkg.sv | 20 ++
 rtl/bcd_digit_sub.sv | 22 ++
 rtl/bcd_sub_seq.sv | 147 ++++++++++++++
 tb/tb_bcd_sub_seq.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/bcd_pkg.sv
// Shared types and constants for the digit-serial BCD datapath blocks.
package bcd_pkg;

    localparam int BCD_DIGIT_W = 4;
    localparam int BCD_RADIX   = 10;
    localparam int BCD_DIGITS  = 4;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CHECK = 3'd1,
        SUB   = 3'd2,
        NEG   = 3'd3,
        DONE  = 3'd4
    } state_t;

    function automatic logic digit_invalid(input logic [BCD_DIGIT_W-1:0] d);
        return d > BCD_DIGIT_W'(BCD_RADIX - 1);
    endfunction

endpackage

// File: rtl/bcd_digit_sub.sv
// One BCD digit of subtraction: minuend - subtrahend - borrow_in, corrected back into 0..9.
module bcd_digit_sub
    import bcd_pkg::*;
(
    input  logic [BCD_DIGIT_W-1:0] minuend,
    input  logic [BCD_DIGIT_W-1:0] subtrahend,
    input  logic                   borrow_in,
    output logic [BCD_DIGIT_W-1:0] digit,
    output logic                   borrow_out
);

    logic [BCD_DIGIT_W:0] t;

    // With digits in 0..9 the raw difference spans -10..9, so the extra top bit is the sign.
    always_comb begin
        t          = {1'b0, minuend} - {1'b0, subtrahend} - {{BCD_DIGIT_W{1'b0}}, borrow_in};
        borrow_out = t[BCD_DIGIT_W];
        digit      = borrow_out ? t[BCD_DIGIT_W-1:0] + BCD_DIGIT_W'(BCD_RADIX)
                                : t[BCD_DIGIT_W-1:0];
    end

endmodule

// File: rtl/bcd_sub_seq.sv
// Digit-serial |a - b| for packed BCD operands with sign and digit-validity flags.
module bcd_sub_seq
    import bcd_pkg::*;
#(
    parameter int DIGITS = BCD_DIGITS
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          start,
    input  logic [BCD_DIGIT_W*DIGITS-1:0] a,
    input  logic [BCD_DIGIT_W*DIGITS-1:0] b,
    output logic                          busy,
    output logic                          done,
    output logic [BCD_DIGIT_W*DIGITS-1:0] diff,
    output logic                          neg,
    output logic                          invalid,
    output state_t                        state
);

    localparam int W     = BCD_DIGIT_W * DIGITS;
    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DIGITS - 1);

    logic [W-1:0]             a_q;
    logic [W-1:0]             b_q;
    logic [W-1:0]             r;
    logic                     borrow;
    logic [IDX_W-1:0]         idx;

    logic [BCD_DIGIT_W-1:0]   op_min;
    logic [BCD_DIGIT_W-1:0]   op_sub;
    logic [BCD_DIGIT_W-1:0]   dig;
    logic                     bout;
    logic [W-1:0]             r_shift;
    logic                     any_bad;

    // SUB consumes a_i - b_i; NEG turns the partial result into its ten's complement (0 - r_i).
    always_comb begin
        op_min  = (state == NEG) ? '0 : a_q[BCD_DIGIT_W-1:0];
        op_sub  = (state == NEG) ? r[BCD_DIGIT_W-1:0] : b_q[BCD_DIGIT_W-1:0];
        r_shift = (r >> BCD_DIGIT_W) | (W'(dig) << (W - BCD_DIGIT_W));
    end

    always_comb begin
        any_bad = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (digit_invalid(a_q[i*BCD_DIGIT_W +: BCD_DIGIT_W]) ||
                digit_invalid(b_q[i*BCD_DIGIT_W +: BCD_DIGIT_W]))
                any_bad = 1'b1;
        end
    end

    bcd_digit_sub u_digit (
        .minuend    (op_min),
        .subtrahend (op_sub),
        .borrow_in  (borrow),
        .digit      (dig),
        .borrow_out (bout)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            r       <= '0;
            borrow  <= 1'b0;
            idx     <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            diff    <= '0;
            neg     <= 1'b0;
            invalid <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        a_q    <= a;
                        b_q    <= b;
                        borrow <= 1'b0;
                        idx    <= '0;
                        busy   <= 1'b1;
                        state  <= CHECK;
                    end else begin
                        state  <= IDLE;
                    end
                end
                CHECK: begin
                    if (any_bad) begin
                        r       <= '0;
                        diff    <= '0;
                        neg     <= 1'b0;
                        invalid <= 1'b1;
                        done    <= 1'b1;
                        busy    <= 1'b0;
                        state   <= DONE;
                    end else begin
                        state   <= SUB;
                    end
                end
                SUB: begin
                    r      <= r_shift;
                    a_q    <= a_q >> BCD_DIGIT_W;
                    b_q    <= b_q >> BCD_DIGIT_W;
                    borrow <= bout;
                    idx    <= idx + IDX_W'(1);
                    if (idx == LAST_IDX) begin
                        idx    <= '0;
                        borrow <= 1'b0;
                        // A final borrow means a < b and the partial result is a - b + 10^DIGITS.
                        if (bout) begin
                            state   <= NEG;
                        end else begin
                            diff    <= r_shift;
                            neg     <= 1'b0;
                            invalid <= 1'b0;
                            done    <= 1'b1;
                            busy    <= 1'b0;
                            state   <= DONE;
                        end
                    end
                end
                NEG: begin
                    r      <= r_shift;
                    borrow <= bout;
                    idx    <= idx + IDX_W'(1);
                    if (idx == LAST_IDX) begin
                        idx     <= '0;
                        borrow  <= 1'b0;
                        diff    <= r_shift;
                        neg     <= 1'b1;
                        invalid <= 1'b0;
                        done    <= 1'b1;
                        busy    <= 1'b0;
                        state   <= DONE;
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bcd_sub_seq.sv
// Randomized and directed bench for bcd_sub_seq against an integer-arithmetic reference model.
module tb_bcd_sub_seq;
    import bcd_pkg::*;

    localparam int DIGITS = 4;
    localparam int W      = 4 * DIGITS;

    logic         clk   = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [W-1:0] a     = '0;
    logic [W-1:0] b     = '0;
    logic         busy;
    logic         done;
    logic [W-1:0] diff;
    logic         neg;
    logic         invalid;
    state_t       state;

    int n_checks = 0;
    int n_pass   = 0;

    // Scoreboard: {invalid, neg, diff} and the expected start-to-done edge count.
    logic [W+1:0] exp_q[$];
    int           lat_q[$];

    always #5 clk = ~clk;

    bcd_sub_seq #(.DIGITS(DIGITS)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .a       (a),
        .b       (b),
        .busy    (busy),
        .done    (done),
        .diff    (diff),
        .neg     (neg),
        .invalid (invalid),
        .state   (state)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    function automatic int bcd_val(input logic [W-1:0] v, output bit bad);
        int acc = 0;
        bad = 1'b0;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            if (v[i*4 +: 4] > 4'd9) bad = 1'b1;
            acc = acc * 10 + int'(v[i*4 +: 4]);
        end
        return acc;
    endfunction

    function automatic logic [W-1:0] to_bcd(input int v);
        logic [W-1:0] res = '0;
        int rem = v;
        for (int i = 0; i < DIGITS; i++) begin
            res[i*4 +: 4] = 4'(rem % 10);
            rem = rem / 10;
        end
        return res;
    endfunction

    function automatic logic [W-1:0] rand_bcd();
        logic [W-1:0] res = '0;
        int d;
        for (int i = 0; i < DIGITS; i++) begin
            d = $urandom_range(0, 9);
            if ($urandom_range(0, 31) == 0) d = $urandom_range(10, 15);
            res[i*4 +: 4] = 4'(d);
        end
        return res;
    endfunction

    task automatic model(input logic [W-1:0] x, input logic [W-1:0] y);
        bit bx, by;
        int vx, vy;
        vx = bcd_val(x, bx);
        vy = bcd_val(y, by);
        if (bx || by) begin
            exp_q.push_back({2'b10, {W{1'b0}}});
            lat_q.push_back(2);
        end else if (vx >= vy) begin
            exp_q.push_back({2'b00, to_bcd(vx - vy)});
            lat_q.push_back(DIGITS + 2);
        end else begin
            exp_q.push_back({2'b01, to_bcd(vy - vx)});
            lat_q.push_back(2 * DIGITS + 2);
        end
    endtask

    // Raises start now; the next rising edge accepts it. glitch_at > 0 re-pulses start mid-operation.
    task automatic run_op(input logic [W-1:0] oa, input logic [W-1:0] ob, input int glitch_at);
        logic [W+1:0] e;
        int           el;
        int           lat;
        model(oa, ob);
        a = oa;
        b = ob;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        a = W'($urandom);
        b = W'($urandom);
        check("busy_after_start", 32'(busy), 32'(1));
        lat = 1;
        while (!done && lat < 4 * DIGITS + 10) begin
            @(posedge clk);
            #1;
            lat++;
            start = (lat == glitch_at) && !done;
            if (start) begin
                a = W'($urandom);
                b = W'($urandom);
            end
        end
        start = 1'b0;
        e  = exp_q.pop_front();
        el = lat_q.pop_front();
        if (!done) check("done_timeout", 32'(0), 32'(1));
        check("diff", 32'(diff), 32'(e[W-1:0]));
        check("neg", 32'(neg), 32'(e[W]));
        check("invalid", 32'(invalid), 32'(e[W+1]));
        check("latency", 32'(lat), 32'(el));
        check("busy_at_done", 32'(busy), 32'(0));
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        bit saw_done;

        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", 32'(busy), 32'(0));
        check("rst_done", 32'(done), 32'(0));
        check("rst_diff", 32'(diff), 32'(0));
        check("rst_neg", 32'(neg), 32'(0));
        check("rst_invalid", 32'(invalid), 32'(0));
        check("rst_state", 32'(state), 32'(IDLE));
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        run_op(16'h1234, 16'h0234, 0);
        run_op(16'h0100, 16'h0001, 0);
        run_op(16'h0005, 16'h0012, 0);
        run_op(16'h0000, 16'h9999, 0);
        run_op(16'h12A4, 16'h0001, 0);
        @(posedge clk);
        #1;

        // Extra start two cycles in must be ignored.
        run_op(16'h0005, 16'h0012, 2);
        repeat (2) @(posedge clk);
        #1;
        check("idle_after_glitch", 32'(state), 32'(IDLE));

        // Start raised in DONE chains straight into the next operation.
        run_op(16'h0042, 16'h0007, 0);
        run_op(16'h0003, 16'h0950, 0);
        run_op(16'h9999, 16'h9999, 0);
        @(posedge clk);
        #1;

        // Reset in the middle of SUB.
        a = 16'h1234;
        b = 16'h0234;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("in_sub_before_reset", 32'(state), 32'(SUB));
        rst_n = 1'b0;
        #1;
        check("midrst_busy", 32'(busy), 32'(0));
        check("midrst_diff", 32'(diff), 32'(0));
        check("midrst_state", 32'(state), 32'(IDLE));
        saw_done = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (8) begin
            @(posedge clk);
            #1;
            if (done) saw_done = 1'b1;
        end
        check("no_done_after_reset", 32'(saw_done), 32'(0));
        run_op(16'h9999, 16'h0000, 0);

        for (int i = 0; i < 40; i++) begin
            int gap;
            gap = $urandom_range(0, 2);
            repeat (gap) begin
                @(posedge clk);
                #1;
            end
            run_op(rand_bcd(), rand_bcd(), 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
